// File: rtl/muldiv_pkg.sv
// Definitions shared by the mult/div unit so the control unit decodes both the same way.
// State encodings, default operand width and the iteration count helper.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef logic [1:0] md_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Operands are extended by one bit so the most negative signed and the
  // largest unsigned value both fit; this is also the number of Booth steps.
  function automatic int iter_count(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/mult_if.sv
// Control-unit side bundle of the sequential multiplier.
// Carries is_unsigned only when MULT_UNSIGNED_EN is defined.
interface mult_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
);

  // Handshake: init is a one-cycle request honoured only while busy is low;
  // busy stays high until the cycle in which done pulses, and hi/lo hold the
  // product from that cycle until the next done, stop or reset. stop aborts.
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             init;
  logic             stop;
`ifdef MULT_UNSIGNED_EN
  logic             is_unsigned;
`endif
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  md_state_t        dbg_state;

  modport master (
    output a, b, init, stop,
`ifdef MULT_UNSIGNED_EN
    output is_unsigned,
`endif
    input  hi, lo, busy, done, dbg_state
  );

  modport slave (
    input  a, b, init, stop,
`ifdef MULT_UNSIGNED_EN
    input  is_unsigned,
`endif
    output hi, lo, busy, done, dbg_state
  );

endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth recoding step: conditional add/subtract of M into A,
// then arithmetic right shift of {A,Q,q_1} by one bit.
module booth_step #(
  parameter int W = 33
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] q,
  input  logic [W-1:0] m,
  input  logic         q_1,
  output logic [W-1:0] acc_nx,
  output logic [W-1:0] q_nx,
  output logic         q_1_nx
);

  logic [W-1:0] sum;

  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
    acc_nx = {sum[W-1], sum[W-1:1]};
    q_nx   = {sum[0], q[W-1:1]};
    q_1_nx = q[0];
  end

endmodule

// File: rtl/mult.sv
// Sequential 32x32->64 Booth multiplier (MIPS MULT), one step per clock.
// MULT_UNSIGNED_EN adds is_unsigned for zero-extended operands (MULTU).
module mult
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic clk,
  input  logic rst,
  mult_if.slave bus
);

  localparam int ITER = iter_count(WIDTH);
  localparam int CW   = $clog2(ITER + 1);

  md_state_t        state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   q;
  logic [WIDTH:0]   m;
  logic             q_1;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             done;

  logic [WIDTH:0]   acc_nx;
  logic [WIDTH:0]   q_nx;
  logic             q_1_nx;
  logic             sgn;

`ifdef MULT_UNSIGNED_EN
  assign sgn = ~bus.is_unsigned;
`else
  assign sgn = 1'b1;
`endif

  booth_step #(.W(WIDTH + 1)) u_step (
    .acc    (acc),
    .q      (q),
    .m      (m),
    .q_1    (q_1),
    .acc_nx (acc_nx),
    .q_nx   (q_nx),
    .q_1_nx (q_1_nx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      acc   <= '0;
      q     <= '0;
      m     <= '0;
      q_1   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else if (bus.stop) begin
      state <= ST_IDLE;
      cnt   <= '0;
      acc   <= '0;
      q     <= '0;
      m     <= '0;
      q_1   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.init) begin
            m     <= {sgn & bus.a[WIDTH-1], bus.a};
            q     <= {sgn & bus.b[WIDTH-1], bus.b};
            acc   <= '0;
            q_1   <= 1'b0;
            cnt   <= CW'(ITER);
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // The exhausted-count edge is spent moving to DONE, not stepping.
          if (cnt == '0) begin
            state <= ST_DONE;
          end else begin
            acc <= acc_nx;
            q   <= q_nx;
            q_1 <= q_1_nx;
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          {hi, lo} <= {acc[WIDTH-2:0], q};
          done     <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.hi        = hi;
  assign bus.lo        = lo;
  assign bus.done      = done;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.dbg_state = state;

endmodule
